// File: rtl/anita3_dig_pkg.sv
// Shared types and sizes for the ANITA-3 digitize scheduler.
package anita3_dig_pkg;

  localparam int NBUF     = 4;
  localparam int BUF_BITS = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    CLEAR     = 2'd3
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/anita3_index_fifo.sv
// Four-entry in-order queue of held buffer indices; drops pushes when full
// unless a pop happens in the same cycle.
module anita3_index_fifo
  import anita3_dig_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [BUF_BITS-1:0] push_data,
  input  logic                pop,
  output logic [BUF_BITS-1:0] head,
  output logic [2:0]          count,
  output logic                overflow
);

  localparam logic [2:0] FULL = 3'(NBUF);

  logic [BUF_BITS-1:0] mem [NBUF];
  logic [1:0]          wr_ptr;
  logic [1:0]          rd_ptr;
  logic                full;
  logic                accept;
  logic                do_pop;

  assign full   = (count == FULL);
  assign do_pop = pop && (count != 3'd0);
  assign accept = push && (!full || do_pop);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !do_pop;
      if (accept) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop) rd_ptr <= rd_ptr + 2'd1;
      case ({accept, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is left out of reset; the pointers and count alone define
  // which entries are valid, so resetting the array buys nothing.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/anita3_digitize_scheduler.sv
// Issues one digitize command at a time for queued LAB buffers, waits for
// done or timeout, then hands the buffer back to the buffer manager.
module anita3_digitize_scheduler
  import anita3_dig_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  logic                clk250_i,
  input  logic                rst_n_i,
  input  logic                trig_i,
  input  logic [BUF_BITS-1:0] trig_buffer_i,
  output logic                dig_start_o,
  output logic [BUF_BITS-1:0] dig_buffer_o,
  input  logic                dig_done_i,
  output logic                clear_o,
  output logic [BUF_BITS-1:0] clear_buffer_o,
  output logic [2:0]          pending_o,
  output logic                busy_o,
  output logic                overflow_o,
  output logic                timeout_o
);

  state_e              state;
  logic [15:0]         timer;
  logic [BUF_BITS-1:0] head;
  logic [2:0]          count;
  logic                fire;

  anita3_index_fifo u_fifo (
    .clk       (clk250_i),
    .rst_n     (rst_n_i),
    .push      (trig_i),
    .push_data (trig_buffer_i),
    .pop       (state == CLEAR),
    .head      (head),
    .count     (count),
    .overflow  (overflow_o)
  );

  // The timer counts cycles since the START cycle, so the expiry decision is
  // taken one cycle early and the registered timeout_o lands on START+TIMEOUT.
  // A done in that decision cycle suppresses the timeout.
  assign fire = (state == WAIT_DONE) && (TIMEOUT_CYCLES != 16'd0) &&
                (timer >= TIMEOUT_CYCLES - 16'd1) && !timeout_o && !dig_done_i;

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      timer          <= '0;
      dig_start_o    <= 1'b0;
      dig_buffer_o   <= '0;
      clear_o        <= 1'b0;
      clear_buffer_o <= '0;
      timeout_o      <= 1'b0;
    end else begin
      dig_start_o <= 1'b0;
      clear_o     <= 1'b0;
      timeout_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (count != 3'd0) begin
            state        <= START;
            dig_start_o  <= 1'b1;
            dig_buffer_o <= head;
            timer        <= '0;
          end
        end
        START: begin
          state <= WAIT_DONE;
          timer <= sat_inc16(timer);
        end
        WAIT_DONE: begin
          timer     <= sat_inc16(timer);
          timeout_o <= fire;
          if (dig_done_i || timeout_o) begin
            state          <= CLEAR;
            clear_o        <= 1'b1;
            clear_buffer_o <= dig_buffer_o;
          end
        end
        CLEAR: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o    = (state != IDLE);
  assign pending_o = count;

endmodule

// File: tb/tb_anita3_digitize_scheduler.sv
// Directed bench for anita3_digitize_scheduler with TIMEOUT_CYCLES=20.
module tb_anita3_digitize_scheduler;

  logic       clk250 = 1'b0;
  logic       rst_n  = 1'b0;
  logic       trig   = 1'b0;
  logic [1:0] trig_buffer = 2'd0;
  logic       done   = 1'b0;
  logic       dig_start_o;
  logic [1:0] dig_buffer_o;
  logic       clear_o;
  logic [1:0] clear_buffer_o;
  logic [2:0] pending_o;
  logic       busy_o;
  logic       overflow_o;
  logic       timeout_o;

  int n_checks = 0;
  int n_err    = 0;

  int n_start, n_clear, n_ovf, n_to, ovf_cyc, to_cyc, peak;
  int start_cyc [8];
  int start_buf [8];
  int clear_cyc [8];
  int clear_buf [8];
  int pend_hist [64];

  anita3_digitize_scheduler #(.TIMEOUT_CYCLES(16'd20)) dut (
    .clk250_i       (clk250),
    .rst_n_i        (rst_n),
    .trig_i         (trig),
    .trig_buffer_i  (trig_buffer),
    .dig_start_o    (dig_start_o),
    .dig_buffer_o   (dig_buffer_o),
    .dig_done_i     (done),
    .clear_o        (clear_o),
    .clear_buffer_o (clear_buffer_o),
    .pending_o      (pending_o),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk250 = ~clk250;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to mid-cycle: outputs are stable, pulse inputs return low.
  task automatic cyc();
    @(negedge clk250);
    trig = 1'b0;
    done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    trig  = 1'b0;
    done  = 1'b0;
    repeat (2) @(negedge clk250);
    rst_n = 1'b1;
  endtask

  // Runs ncyc cycles numbered from 0. Triggers 0..ntrig-1 carry buffers
  // 0,1,2,3,1; done follows each start by done_delay cycles (0 = never).
  task automatic run(input int ntrig, input int done_delay, input int late_done,
                     input int extra_cyc, input logic [1:0] extra_buf, input int ncyc);
    int next_done;
    next_done = -1;
    n_start = 0; n_clear = 0; n_ovf = 0; n_to = 0;
    ovf_cyc = -1; to_cyc = -1; peak = 0;
    for (int i = 0; i < 8; i++) begin
      start_cyc[i] = -1; start_buf[i] = -1; clear_cyc[i] = -1; clear_buf[i] = -1;
    end
    for (int i = 0; i < 64; i++) pend_hist[i] = -1;
    for (int c = 0; c < ncyc; c++) begin
      cyc();
      if (c < 64) pend_hist[c] = int'(pending_o);
      if (int'(pending_o) > peak) peak = int'(pending_o);
      if (dig_start_o) begin
        if (n_start < 8) begin
          start_cyc[n_start] = c;
          start_buf[n_start] = int'(dig_buffer_o);
        end
        n_start++;
        if (done_delay > 0) next_done = c + done_delay;
      end
      if (clear_o) begin
        if (n_clear < 8) begin
          clear_cyc[n_clear] = c;
          clear_buf[n_clear] = int'(clear_buffer_o);
        end
        n_clear++;
      end
      if (overflow_o) begin n_ovf++; ovf_cyc = c; end
      if (timeout_o)  begin n_to++;  to_cyc  = c; end
      if (c < ntrig) begin
        trig = 1'b1;
        trig_buffer = (c < 4) ? 2'(c) : 2'd1;
      end
      if (c == extra_cyc) begin
        trig = 1'b1;
        trig_buffer = extra_buf;
      end
      if (c == next_done || c == late_done) done = 1'b1;
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_outputs",
          {19'd0, dig_start_o, dig_buffer_o, clear_o, clear_buffer_o, pending_o,
           busy_o, overflow_o, timeout_o}, 32'd0);
    do_reset();

    // Single trigger, buffer 2 at cycle 0, done at cycle 10
    run(0, 8, -1, 0, 2'd2, 16);
    check("t1_start_cycle", start_cyc[0], 2);
    check("t1_start_buf", start_buf[0], 2);
    check("t1_clear_cycle", clear_cyc[0], 11);
    check("t1_clear_buf", clear_buf[0], 2);
    check("t1_pending_n1", pend_hist[1], 1);
    check("t1_pending_d1", pend_hist[11], 1);
    check("t1_pending_d2", pend_hist[12], 0);
    check("t1_clear_count", n_clear, 1);
    do_reset();

    // Four back-to-back triggers, done 5 cycles after each start
    run(4, 5, -1, -1, 2'd0, 40);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_start_cycle%0d", i), start_cyc[i], 2 + 8 * i);
      check($sformatf("t2_start_buf%0d", i), start_buf[i], i);
    end
    check("t2_clear_count", n_clear, 4);
    check("t2_pending_peak", peak, 4);
    check("t2_no_overflow", n_ovf, 0);
    check("t2_pending_end", pend_hist[33], 0);
    do_reset();

    // Five triggers before any done: the fifth is dropped
    run(5, 5, -1, -1, 2'd0, 40);
    check("t3_overflow_count", n_ovf, 1);
    check("t3_overflow_cycle", ovf_cyc, 5);
    check("t3_pending_full", pend_hist[5], 4);
    check("t3_start_count", n_start, 4);
    check("t3_clear_count", n_clear, 4);
    check("t3_last_buf", start_buf[3], 3);
    do_reset();

    // Timeout, then a late done that must be ignored
    run(0, 0, 26, 0, 2'd3, 35);
    check("t4_timeout_cycle", to_cyc, 22);
    check("t4_timeout_count", n_to, 1);
    check("t4_clear_cycle", clear_cyc[0], 23);
    check("t4_clear_buf", clear_buf[0], 3);
    check("t4_clear_count", n_clear, 1);
    check("t4_start_count", n_start, 1);
    check("t4_pending_idle", pend_hist[24], 0);
    check("t4_idle_end", busy_o, 0);
    do_reset();

    // Trigger in the CLEAR cycle with a full queue
    run(4, 5, -1, 8, 2'd0, 45);
    check("t5_no_overflow", n_ovf, 0);
    check("t5_pending_stays", pend_hist[9], 4);
    check("t5_start_count", n_start, 5);
    check("t5_second_buf", start_buf[1], 1);
    check("t5_last_buf", start_buf[4], 0);
    check("t5_last_cycle", start_cyc[4], 34);
    check("t5_clear_count", n_clear, 5);
    do_reset();

    // Reset asserted during WAIT_DONE
    run(0, 0, -1, 0, 2'd1, 5);
    check("t6_busy_before", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("t6_outputs_in_reset",
          {19'd0, dig_start_o, dig_buffer_o, clear_o, clear_buffer_o, pending_o,
           busy_o, overflow_o, timeout_o}, 32'd0);
    @(negedge clk250);
    rst_n = 1'b1;
    run(0, 0, -1, -1, 2'd0, 12);
    check("t6_no_clear", n_clear, 0);
    check("t6_no_start", n_start, 0);
    check("t6_pending_zero", pending_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
